// File: rtl/shared_reg_sched.sv
// shared_reg_sched: round-robin arbiter in front of one shared WIDTH-bit
// register and adder. Each grant runs accept -> execute -> respond, so
// register updates from different requesters never overlap.
module shared_reg_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = $clog2(N_REQ)
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_data,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [WIDTH-1:0]       resp_data,
  output logic [WIDTH-1:0]       reg_value
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_READ   = 2'b00,
    OP_WRITE  = 2'b01,
    OP_ADD    = 2'b10,
    OP_DOUBLE = 2'b11
  } op_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rrPtr_q, rrPtr_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   id_q, id_d;

  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   cand;
  logic             found;
  logic [N_REQ-1:0] grant;

  // Search req_valid starting at rrPtr_q; the index wraps for free because N_REQ is a power of two.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = rrPtr_q + IDW'(k);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next-state, operand capture, register update and the one-hot grant.
  always_comb begin
    state_d = state_q;
    rrPtr_d = rrPtr_q;
    reg_d   = reg_q;
    op_d    = op_q;
    data_d  = data_q;
    id_d    = id_q;
    grant   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant[winner] = 1'b1;
          op_d    = req_op[2*int'(winner) +: 2];
          data_d  = req_data[WIDTH*int'(winner) +: WIDTH];
          id_d    = winner;
          rrPtr_d = winner + IDW'(1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (op_q)
          OP_WRITE:  reg_d = data_q;
          OP_ADD:    reg_d = reg_q + data_q;
          OP_DOUBLE: reg_d = reg_q + reg_q + data_q;
          default:   reg_d = reg_q;
        endcase
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, shared register and latched transaction fields.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rrPtr_q <= '0;
      reg_q   <= '0;
      op_q    <= '0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      rrPtr_q <= rrPtr_d;
      reg_q   <= reg_d;
      op_q    <= op_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  // Grants are masked while reset is held so nothing looks acceptable during reset.
  always_comb begin
    req_ready  = rst_n ? grant : '0;
    resp_valid = (state_q == RESP);
    resp_id    = id_q;
    resp_data  = reg_q;
    reg_value  = reg_q;
  end

endmodule

// File: tb/tb_shared_reg_sched.sv
// tb_shared_reg_sched: directed vector table for the scheduler plus
// hand-written sequences for reset, backpressure and operand sampling.
module tb_shared_reg_sched;

  logic        clock;
  logic        rst_n;
  logic [3:0]  reqValid;
  logic [3:0]  reqReady;
  logic [7:0]  reqOp;
  logic [31:0] reqData;
  logic        respValid;
  logic        respReady;
  logic [1:0]  respId;
  logic [7:0]  respData;
  logic [7:0]  regValue;

  int assertCount;
  int failCount;

  typedef struct {
    logic        doReset;
    logic [3:0]  valid;
    logic [7:0]  ops;
    logic [31:0] data;
    logic [1:0]  expId;
    logic [7:0]  expData;
  } vec_t;

  vec_t tbl [18];

  shared_reg_sched #(.N_REQ(4), .WIDTH(8)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .req_valid  (reqValid),
    .req_ready  (reqReady),
    .req_op     (reqOp),
    .req_data   (reqData),
    .resp_valid (respValid),
    .resp_ready (respReady),
    .resp_id    (respId),
    .resp_data  (respData),
    .reg_value  (regValue)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered just after a falling edge; holds reset for one cycle and leaves at a falling edge.
  task automatic applyReset(input string tag);
    rst_n = 1'b0;
    #1;
    checkOutput({tag, " rst req_ready"}, 32'(reqReady), 32'h0);
    checkOutput({tag, " rst resp_valid"}, 32'(respValid), 32'h0);
    checkOutput({tag, " rst reg_value"}, 32'(regValue), 32'h0);
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  // One full transaction from an IDLE falling edge to the next IDLE falling edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.doReset) applyReset(tag);
    reqValid  = v.valid;
    reqOp     = v.ops;
    reqData   = v.data;
    respReady = 1'b1;
    #1;
    checkOutput({tag, " grant"}, 32'(reqReady), 32'(4'b0001 << v.expId));
    @(negedge clock);
    #1;
    checkOutput({tag, " exec req_ready"}, 32'(reqReady), 32'h0);
    checkOutput({tag, " exec resp_valid"}, 32'(respValid), 32'h0);
    @(negedge clock);
    #1;
    checkOutput({tag, " resp_valid"}, 32'(respValid), 32'h1);
    checkOutput({tag, " resp_id"}, 32'(respId), 32'(v.expId));
    checkOutput({tag, " resp_data"}, 32'(respData), 32'(v.expData));
    checkOutput({tag, " reg_value"}, 32'(regValue), 32'(v.expData));
    @(negedge clock);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    clock     = 1'b0;
    rst_n     = 1'b0;
    reqValid  = '0;
    reqOp     = '0;
    reqData   = '0;
    respReady = 1'b1;

    // Single client, then wrap-around arithmetic, all from requester 0.
    tbl[0]  = '{1'b0, 4'b0001, 8'h01, 32'h0000_0011, 2'd0, 8'h11};
    tbl[1]  = '{1'b0, 4'b0001, 8'h02, 32'h0000_0005, 2'd0, 8'h16};
    tbl[2]  = '{1'b0, 4'b0001, 8'h00, 32'h0000_0000, 2'd0, 8'h16};
    tbl[3]  = '{1'b0, 4'b0001, 8'h01, 32'h0000_00F0, 2'd0, 8'hF0};
    tbl[4]  = '{1'b0, 4'b0001, 8'h02, 32'h0000_0020, 2'd0, 8'h10};
    tbl[5]  = '{1'b0, 4'b0001, 8'h01, 32'h0000_0021, 2'd0, 8'h21};
    tbl[6]  = '{1'b0, 4'b0001, 8'h03, 32'h0000_0010, 2'd0, 8'h52};
    tbl[7]  = '{1'b0, 4'b0001, 8'h01, 32'h0000_0080, 2'd0, 8'h80};
    tbl[8]  = '{1'b0, 4'b0001, 8'h03, 32'h0000_0001, 2'd0, 8'h01};
    // Fairness from a fresh reset: all four READ continuously.
    tbl[9]  = '{1'b1, 4'b1111, 8'h00, 32'h0000_0000, 2'd0, 8'h00};
    tbl[10] = '{1'b0, 4'b1111, 8'h00, 32'h0000_0000, 2'd1, 8'h00};
    tbl[11] = '{1'b0, 4'b1111, 8'h00, 32'h0000_0000, 2'd2, 8'h00};
    tbl[12] = '{1'b0, 4'b1111, 8'h00, 32'h0000_0000, 2'd3, 8'h00};
    tbl[13] = '{1'b0, 4'b1111, 8'h00, 32'h0000_0000, 2'd0, 8'h00};
    tbl[14] = '{1'b0, 4'b1111, 8'h00, 32'h0000_0000, 2'd1, 8'h00};
    // Only 1 and 3 valid with the pointer at 2.
    tbl[15] = '{1'b0, 4'b1010, 8'h00, 32'h0000_0000, 2'd3, 8'h00};
    tbl[16] = '{1'b0, 4'b1010, 8'h00, 32'h0000_0000, 2'd1, 8'h00};
    tbl[17] = '{1'b0, 4'b1010, 8'h00, 32'h0000_0000, 2'd3, 8'h00};

    #1;
    checkOutput("por req_ready", 32'(reqReady), 32'h0);
    checkOutput("por resp_valid", 32'(respValid), 32'h0);
    checkOutput("por resp_id", 32'(respId), 32'h0);
    checkOutput("por resp_data", 32'(respData), 32'h0);
    checkOutput("por reg_value", 32'(regValue), 32'h0);
    @(negedge clock);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) applyStimulus(tbl[i], i);

    // Reset during EXEC of a WRITE 0x55, with the register previously non-zero.
    applyStimulus('{1'b0, 4'b0001, 8'h01, 32'h0000_0033, 2'd0, 8'h33}, 100);
    reqValid = 4'b0001;
    reqOp    = 8'h01;
    reqData  = 32'h0000_0055;
    #1;
    checkOutput("rstExec grant", 32'(reqReady), 32'h1);
    @(negedge clock);
    rst_n = 1'b0;
    #1;
    checkOutput("rstExec req_ready", 32'(reqReady), 32'h0);
    checkOutput("rstExec resp_valid", 32'(respValid), 32'h0);
    checkOutput("rstExec resp_id", 32'(respId), 32'h0);
    checkOutput("rstExec resp_data", 32'(respData), 32'h0);
    checkOutput("rstExec reg_value", 32'(regValue), 32'h0);
    reqValid = '0;
    @(negedge clock);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("rstExec no resp", 32'(respValid), 32'h0);
      checkOutput("rstExec reg after", 32'(regValue), 32'h0);
      @(negedge clock);
    end

    // Reset during RESP of requester 1 WRITE 0x44.
    reqValid = 4'b0010;
    reqOp    = 8'h04;
    reqData  = 32'h0000_4400;
    #1;
    checkOutput("rstResp grant", 32'(reqReady), 32'h2);
    @(negedge clock);
    @(negedge clock);
    #1;
    checkOutput("rstResp resp_valid", 32'(respValid), 32'h1);
    checkOutput("rstResp resp_id", 32'(respId), 32'h1);
    checkOutput("rstResp resp_data", 32'(respData), 32'h44);
    rst_n = 1'b0;
    #1;
    checkOutput("rstResp drop valid", 32'(respValid), 32'h0);
    checkOutput("rstResp drop id", 32'(respId), 32'h0);
    checkOutput("rstResp drop data", 32'(respData), 32'h0);
    reqValid = '0;
    @(negedge clock);
    rst_n = 1'b1;

    // Backpressure: stall in RESP while everyone is requesting.
    reqValid  = 4'b1111;
    reqOp     = 8'h01;
    reqData   = 32'h0000_005A;
    respReady = 1'b1;
    #1;
    checkOutput("bp grant0", 32'(reqReady), 32'h1);
    @(negedge clock);
    @(negedge clock);
    respReady = 1'b0;
    #1;
    checkOutput("bp resp_valid", 32'(respValid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      #1;
      checkOutput("bp hold valid", 32'(respValid), 32'h1);
      checkOutput("bp hold id", 32'(respId), 32'h0);
      checkOutput("bp hold data", 32'(respData), 32'h5A);
      checkOutput("bp hold req_ready", 32'(reqReady), 32'h0);
    end
    @(negedge clock);
    respReady = 1'b1;
    #1;
    checkOutput("bp release req_ready", 32'(reqReady), 32'h0);
    checkOutput("bp release valid", 32'(respValid), 32'h1);
    @(negedge clock);
    #1;
    checkOutput("bp next grant", 32'(reqReady), 32'h2);
    @(negedge clock);
    @(negedge clock);
    #1;
    checkOutput("bp next id", 32'(respId), 32'h1);
    checkOutput("bp next data", 32'(respData), 32'h5A);
    @(negedge clock);

    // Operand sampling: requester 2 ADD 0x03, data changes after accept.
    reqValid = 4'b0100;
    reqOp    = 8'h20;
    reqData  = 32'h0003_0000;
    #1;
    checkOutput("samp grant", 32'(reqReady), 32'h4);
    @(negedge clock);
    reqData = 32'h0009_0000;
    @(negedge clock);
    #1;
    checkOutput("samp id", 32'(respId), 32'h2);
    checkOutput("samp data", 32'(respData), 32'h5D);
    @(negedge clock);

    // Withdrawn request: requester 0 drops before its turn.
    reqValid = 4'b1001;
    reqOp    = 8'h41;
    reqData  = 32'h7700_00EE;
    #1;
    checkOutput("wd grant3", 32'(reqReady), 32'h8);
    @(negedge clock);
    reqValid = '0;
    @(negedge clock);
    #1;
    checkOutput("wd id", 32'(respId), 32'h3);
    checkOutput("wd data", 32'(respData), 32'h77);
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput("wd idle ready", 32'(reqReady), 32'h0);
      checkOutput("wd idle resp", 32'(respValid), 32'h0);
      checkOutput("wd idle reg", 32'(regValue), 32'h77);
      @(negedge clock);
    end
    reqValid = 4'b0011;
    reqOp    = 8'h00;
    reqData  = 32'h0;
    #1;
    checkOutput("wd ptr grant0", 32'(reqReady), 32'h1);
    @(negedge clock);
    @(negedge clock);
    #1;
    checkOutput("wd final id", 32'(respId), 32'h0);
    checkOutput("wd final data", 32'(respData), 32'h77);
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/shared_reg_sched.md
# shared_reg_sched

Round-robin scheduler that shares one WIDTH-bit state register and its add datapath among N_REQ requesters. Each granted request runs as a short sequenced transaction: accept, execute, respond. The block serialises all read, write and accumulate traffic to the register, so requesters never see a torn or overlapping update. It sits between independent client blocks and the single shared register/adder resource.

## Interface
- N_REQ, 4: number of requesters; power of two, at least 2.
- WIDTH, 8: register and data width in bits.
- clock  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  bit i: requester i has a pending request.
- req_ready  out  N_REQ  one-hot grant; request i is accepted on any edge where req_valid[i] and req_ready[i] are both 1.
- req_op  in  2*N_REQ  op for requester i at [2i+:2]: 00 READ, 01 WRITE, 10 ADD, 11 DOUBLE.
- req_data  in  WIDTH*N_REQ  operand for requester i at [i*WIDTH+:WIDTH].
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumer accepts.
- resp_id  out  log2(N_REQ)  index of the requester being answered.
- resp_data  out  WIDTH  register value after the op.
- reg_value  out  WIDTH  current contents of the shared register.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Combinationally selects a winner from req_valid, searching rr_ptr, rr_ptr+1, … mod N_REQ.
  - Drives req_ready one-hot for that winner only. req_ready is all-zero when no request is valid, and in every state other than IDLE.
  - On the accept edge: latch op, data and id; set rr_ptr = winner+1 mod N_REQ; go to EXEC.
- EXEC, at the edge leaving this state:
  - READ: register unchanged.
  - WRITE: reg = data.
  - ADD: reg = reg + data.
  - DOUBLE: reg = reg + reg + data.
  - Go to RESP.
- RESP:
  - resp_valid=1, resp_id=latched id, resp_data=reg_value (the post-op value).
  - On the edge where resp_ready=1, go to IDLE.
  - While resp_ready=0, resp_valid, resp_id and resp_data hold stable.
- Arithmetic: all sums are truncated to WIDTH bits (mod 2^WIDTH). No carry or overflow is reported.
- Operand capture: req_op and req_data are sampled only on the accept edge. Changes at any other time have no effect. A request withdrawn before its grant is simply skipped.
- rr_ptr changes only on an accept. Non-requesting slots do not advance it.
- Reset (rst_n=0, any state, any time), asynchronously:
  - state=IDLE, rr_ptr=0, reg=0, latched op/data/id=0.
  - req_ready=0, resp_valid=0, resp_id=0, resp_data=0, reg_value=0.
  - A transaction interrupted by reset is dropped with no response.
  - After release, the first edge with rst_n=1 may accept a request.

## Timing
- Accept in cycle T (IDLE).
- T+1: EXEC.
- Register update at the edge ending T+1.
- T+2: RESP. resp_valid=1 and reg_value already shows the new value.
- With resp_ready held at 1, the next accept can occur in T+3. Peak rate is one transaction per 3 cycles.
- Each cycle of resp_ready=0 in RESP adds one cycle of latency. No request is accepted during that stall.
- req_ready is a Mealy output of IDLE and req_valid. There is no combinational path from resp_ready to req_ready.
- Simultaneous requests: exactly one grant per IDLE cycle. The others remain pending until later rounds.

## Test plan
- Reset:
  - Drive rst_n low during EXEC of a WRITE 0x55 → all outputs go to 0 immediately, no response is issued, and reg_value=0 after release.
  - Repeat with reset asserted during RESP → resp_valid drops the same cycle.
- Single client sequence:
  - Requester 0 issues WRITE 0x11, then ADD 0x05, then READ.
  - Responses: (id0, 0x11), (id0, 0x16), (id0, 0x16).
  - Each resp_valid appears 2 cycles after its accept, with accepts 3 cycles apart.
- Wrap-around:
  - WRITE 0xF0 then ADD 0x20 → resp_data 0x10.
  - DOUBLE 0x10 with reg=0x21 → resp_data 0x52.
  - DOUBLE 0x01 with reg=0x80 → resp_data 0x01.
- Round-robin fairness:
  - All 4 valid continuously from reset, with a READ each → grant order 0,1,2,3,0,1.
  - Then only requesters 1 and 3 valid, with rr_ptr=2 → order 3,1,3.
- Backpressure:
  - Hold resp_ready=0 for 5 cycles in RESP while req_valid=4'b1111.
  - Required: resp_valid, resp_id and resp_data stay stable, req_ready stays 0 throughout, and the next accept comes exactly 1 cycle after resp_ready rises.
- Operand sampling:
  - Requester 2 changes req_data from 0x03 to 0x09 one cycle after its accept → its ADD uses 0x03.
  - A requester that drops valid before its grant gets no response, and rr_ptr is unchanged for it.
